// File: rtl/perf_counter_bank_if.sv
// rtl/perf_counter_bank_if.sv - host/debug read port of the performance counter bank
interface perf_counter_bank_if #(
    parameter int NUM_CH = 4
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic            rd_req;
    logic [CH_W-1:0] rd_ch;
    logic            rd_hi;
    logic            rd_valid;
    logic [31:0]     rd_data;

    modport master (
        output rd_req,
        output rd_ch,
        output rd_hi,
        input  rd_valid,
        input  rd_data
    );

    modport slave (
        input  rd_req,
        input  rd_ch,
        input  rd_hi,
        output rd_valid,
        output rd_data
    );
endinterface

// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - multi-channel event counters with snapshot shadows and sticky overflow
module perf_counter_bank #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 64,
    parameter bit SATURATE = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic [NUM_CH-1:0] evt,
    input  logic              clr,
    input  logic              snap,
    output logic [NUM_CH-1:0] ovf,
    perf_counter_bank_if.slave rd
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0][CNT_W-1:0] cnt;
    logic [NUM_CH-1:0][CNT_W-1:0] shadow;
    logic [63:0]                  rd_src;

    // Live counters: clear wins over counting, halt freezes counting only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            ovf <= '0;
        end else if (clr) begin
            cnt <= '0;
            ovf <= '0;
        end else if (!halt) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (evt[i]) begin
                    if (&cnt[i]) begin
                        ovf[i] <= 1'b1;
                        if (!SATURATE) begin
                            cnt[i] <= '0;
                        end
                    end else begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Shadow copy of every channel taken from the same cycle, before that cycle's increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
        end else if (snap) begin
            shadow <= cnt;
        end
    end

    // Select the requested shadow, zero-extended; unmapped channel numbers read as zero.
    always_comb begin
        rd_src = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd.rd_ch == CH_W'(i)) begin
                rd_src = 64'(shadow[i]);
            end
        end
    end

    // One-cycle read response; data holds between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd.rd_valid <= 1'b0;
            rd.rd_data  <= '0;
        end else begin
            rd.rd_valid <= rd.rd_req;
            if (rd.rd_req) begin
                rd.rd_data <= rd.rd_hi ? rd_src[63:32] : rd_src[31:0];
            end
        end
    end
endmodule

// File: tb/tb_perf_counter_bank.sv
// tb/tb_perf_counter_bank.sv - self-checking bench for perf_counter_bank
module tb_perf_counter_bank;
    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       halt   = 1'b0;
    logic [3:0] evt    = '0;
    logic       clr    = 1'b0;
    logic       snap   = 1'b0;
    logic [3:0] ovf;
    logic [2:0] evt_s  = '0;
    logic       clr_s  = 1'b0;
    logic       snap_s = 1'b0;
    logic [2:0] ovf_w;
    logic [2:0] ovf_s;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: 64-bit main bank, and two 4-bit banks (wrap / saturate).
    longint unsigned mc[4];
    longint unsigned ms[4];
    logic [3:0]      mo;
    int unsigned     cw[3], cs[3], sw[3], ss[3];
    logic [2:0]      ow, os;

    perf_counter_bank_if #(.NUM_CH(4)) mi();
    perf_counter_bank_if #(.NUM_CH(3)) wi();
    perf_counter_bank_if #(.NUM_CH(3)) si();

    perf_counter_bank #(.NUM_CH(4), .CNT_W(64), .SATURATE(1'b0)) u_dut (
        .clk(clk), .rst(rst), .halt(halt), .evt(evt), .clr(clr), .snap(snap), .ovf(ovf), .rd(mi)
    );
    perf_counter_bank #(.NUM_CH(3), .CNT_W(4), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .halt(halt), .evt(evt_s), .clr(clr_s), .snap(snap_s), .ovf(ovf_w), .rd(wi)
    );
    perf_counter_bank #(.NUM_CH(3), .CNT_W(4), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .halt(halt), .evt(evt_s), .clr(clr_s), .snap(snap_s), .ovf(ovf_s), .rd(si)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sel(input longint unsigned v, input bit hi);
        logic [63:0] t;
        t = v;
        return hi ? t[63:32] : t[31:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mc[i] = 0;
            ms[i] = 0;
        end
        for (int i = 0; i < 3; i++) begin
            cw[i] = 0; cs[i] = 0; sw[i] = 0; ss[i] = 0;
        end
        mo = '0; ow = '0; os = '0;
    endtask

    // One clock: model applies this cycle's inputs, then returns at the falling edge.
    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (snap) ms[i] = mc[i];
            if (clr) begin
                mc[i] = 0;
                mo[i] = 1'b0;
            end else if (!halt && evt[i]) begin
                if (mc[i] == 64'hFFFF_FFFF_FFFF_FFFF) mo[i] = 1'b1;
                mc[i] = mc[i] + 1;
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (snap_s) begin
                sw[i] = cw[i];
                ss[i] = cs[i];
            end
            if (clr_s) begin
                cw[i] = 0; cs[i] = 0; ow[i] = 1'b0; os[i] = 1'b0;
            end else if (!halt && evt_s[i]) begin
                if (cw[i] == 15) begin
                    ow[i] = 1'b1;
                    cw[i] = 0;
                end else begin
                    cw[i] = cw[i] + 1;
                end
                if (cs[i] == 15) os[i] = 1'b1;
                else cs[i] = cs[i] + 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic rd_main(input int ch, input bit hi, input bit with_snap,
                           input logic [31:0] exp, input string tag);
        mi.rd_req = 1'b1;
        mi.rd_ch  = 2'(ch);
        mi.rd_hi  = hi;
        snap      = with_snap;
        tick();
        mi.rd_req = 1'b0;
        snap      = 1'b0;
        check({tag, "_vld"}, 64'(mi.rd_valid), 64'd1);
        check(tag, 64'(mi.rd_data), 64'(exp));
    endtask

    task automatic rd_small(input int ch, input bit hi, input logic [31:0] exp_w,
                            input logic [31:0] exp_s, input string tag);
        wi.rd_req = 1'b1; wi.rd_ch = 2'(ch); wi.rd_hi = hi;
        si.rd_req = 1'b1; si.rd_ch = 2'(ch); si.rd_hi = hi;
        tick();
        wi.rd_req = 1'b0;
        si.rd_req = 1'b0;
        check({tag, "_w_vld"}, 64'(wi.rd_valid), 64'd1);
        check({tag, "_s_vld"}, 64'(si.rd_valid), 64'd1);
        check({tag, "_w"}, 64'(wi.rd_data), 64'(exp_w));
        check({tag, "_s"}, 64'(si.rd_data), 64'(exp_s));
    endtask

    initial begin
        mi.rd_req = 1'b0; mi.rd_ch = '0; mi.rd_hi = 1'b0;
        wi.rd_req = 1'b0; wi.rd_ch = '0; wi.rd_hi = 1'b0;
        si.rd_req = 1'b0; si.rd_ch = '0; si.rd_hi = 1'b0;
        model_reset();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_vld", 64'(mi.rd_valid), 64'd0);
        check("rst_data", 64'(mi.rd_data), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_ovf_w", 64'(ovf_w), 64'd0);
        check("rst_ovf_s", 64'(ovf_s), 64'd0);
        check("rst_vld_w", 64'(wi.rd_valid), 64'd0);
        rst = 1'b0;

        // Cycle count on ch0
        evt = 4'b0001;
        ticks(100);
        evt = '0;
        snap = 1'b1; tick(); snap = 1'b0;
        rd_main(0, 1'b0, 1'b0, 32'd100, "cyc_lo");
        rd_main(0, 1'b1, 1'b0, 32'd0, "cyc_hi");
        rd_main(1, 1'b0, 1'b0, 32'd0, "cyc_ch1");
        rd_main(2, 1'b0, 1'b0, 32'd0, "cyc_ch2");
        rd_main(3, 1'b0, 1'b0, 32'd0, "cyc_ch3");
        rd_main(0, 1'b0, 1'b0, 32'd100, "cyc_lo2");
        tick();
        check("idle_vld", 64'(mi.rd_valid), 64'd0);
        check("idle_hold", 64'(mi.rd_data), 64'd100);

        // Halt freeze, snap honoured during halt
        clr = 1'b1; tick(); clr = 1'b0;
        evt = 4'hF;
        ticks(10);
        halt = 1'b1;
        ticks(2);
        snap = 1'b1; tick(); snap = 1'b0;
        for (int c = 0; c < 4; c++) rd_main(c, 1'b0, 1'b0, 32'd10, "halt_snap");
        halt = 1'b0;
        ticks(10);
        evt = '0;
        snap = 1'b1; tick(); snap = 1'b0;
        for (int c = 0; c < 4; c++) rd_main(c, 1'b0, 1'b0, 32'd20, "halt_cnt");

        // Read-and-clear
        clr = 1'b1; tick(); clr = 1'b0;
        evt = 4'b0010; ticks(7); evt = '0;
        snap = 1'b1; clr = 1'b1; tick(); snap = 1'b0; clr = 1'b0;
        evt = 4'b0010; ticks(3); evt = '0;
        rd_main(1, 1'b0, 1'b0, 32'd7, "rc_first");
        snap = 1'b1; tick(); snap = 1'b0;
        rd_main(1, 1'b0, 1'b0, 32'd3, "rc_second");

        // Read/snap collision
        clr = 1'b1; tick(); clr = 1'b0;
        evt = 4'b0100; ticks(5); evt = '0;
        snap = 1'b1; tick(); snap = 1'b0;
        evt = 4'b0100; ticks(4); evt = '0;
        rd_main(2, 1'b0, 1'b1, 32'd5, "coll_old");
        rd_main(2, 1'b0, 1'b0, 32'd9, "coll_new");

        // Wide value on ch3
        force u_dut.cnt = {64'h0000_0001_0000_0002, 192'd0};
        mc[3] = 64'h0000_0001_0000_0002;
        mc[2] = 0; mc[1] = 0; mc[0] = 0;
        snap = 1'b1; tick(); snap = 1'b0;
        release u_dut.cnt;
        clr = 1'b1; tick(); clr = 1'b0;
        rd_main(3, 1'b0, 1'b0, 32'd2, "wide_lo");
        rd_main(3, 1'b1, 1'b0, 32'd1, "wide_hi");
        rd_main(0, 1'b1, 1'b0, 32'd0, "wide_ch0_hi");

        // Wrap vs saturate on the 4-bit banks
        evt_s = 3'b001;
        ticks(15);
        check("pre_ovf_w", 64'(ovf_w), 64'd0);
        check("pre_ovf_s", 64'(ovf_s), 64'd0);
        tick();
        check("edge_ovf_w", 64'(ovf_w), 64'd1);
        check("edge_ovf_s", 64'(ovf_s), 64'd1);
        tick();
        evt_s = '0;
        snap_s = 1'b1; tick(); snap_s = 1'b0;
        rd_small(0, 1'b0, 32'd1, 32'd15, "ws17");
        rd_small(0, 1'b1, 32'd0, 32'd0, "ws_hi");
        rd_small(3, 1'b0, 32'd0, 32'd0, "ws_oor");
        check("sticky_ovf_w", 64'(ovf_w), 64'd1);
        check("sticky_ovf_s", 64'(ovf_s), 64'd1);
        clr_s = 1'b1; tick(); clr_s = 1'b0;
        check("clr_ovf_w", 64'(ovf_w), 64'd0);
        check("clr_ovf_s", 64'(ovf_s), 64'd0);
        snap_s = 1'b1; tick(); snap_s = 1'b0;
        rd_small(0, 1'b0, 32'd0, 32'd0, "ws_clr");

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            bit          do_rd;
            bit          rh;
            int          rc;
            int          sc;
            logic [31:0] em, eww, ess;
            evt    = 4'($urandom);
            evt_s  = 3'($urandom);
            halt   = ($urandom_range(0, 3) == 0);
            clr    = ($urandom_range(0, 19) == 0);
            clr_s  = ($urandom_range(0, 19) == 0);
            snap   = ($urandom_range(0, 4) == 0);
            snap_s = ($urandom_range(0, 4) == 0);
            do_rd  = 1'($urandom_range(0, 1));
            rh     = 1'($urandom_range(0, 1));
            rc     = $urandom_range(0, 3);
            sc     = $urandom_range(0, 3);
            em     = sel(ms[rc], rh);
            eww    = (sc < 3 && !rh) ? 32'(sw[sc]) : 32'd0;
            ess    = (sc < 3 && !rh) ? 32'(ss[sc]) : 32'd0;
            mi.rd_req = do_rd; mi.rd_ch = 2'(rc); mi.rd_hi = rh;
            wi.rd_req = do_rd; wi.rd_ch = 2'(sc); wi.rd_hi = rh;
            si.rd_req = do_rd; si.rd_ch = 2'(sc); si.rd_hi = rh;
            tick();
            check("rnd_vld", 64'(mi.rd_valid), 64'(do_rd));
            if (do_rd) begin
                check("rnd_rd", 64'(mi.rd_data), 64'(em));
                check("rnd_rd_w", 64'(wi.rd_data), 64'(eww));
                check("rnd_rd_s", 64'(si.rd_data), 64'(ess));
            end
            check("rnd_ovf", 64'(ovf), 64'(mo));
            check("rnd_ovf_w", 64'(ovf_w), 64'(ow));
            check("rnd_ovf_s", 64'(ovf_s), 64'(os));
        end
        evt = '0; evt_s = '0; halt = 1'b0; clr = 1'b0; clr_s = 1'b0; snap = 1'b0; snap_s = 1'b0;
        mi.rd_req = 1'b0; wi.rd_req = 1'b0; si.rd_req = 1'b0;

        // Reset in the middle of a read
        mi.rd_req = 1'b1; mi.rd_ch = 2'd3; mi.rd_hi = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_vld", 64'(mi.rd_valid), 64'd0);
        check("mid_rst_data", 64'(mi.rd_data), 64'd0);
        check("mid_rst_ovf_w", 64'(ovf_w), 64'd0);
        mi.rd_req = 1'b0;
        @(negedge clk);
        check("rst_next_vld", 64'(mi.rd_valid), 64'd0);
        rst = 1'b0;
        model_reset();
        rd_main(3, 1'b0, 1'b0, 32'd0, "post_rst_sh");
        rd_small(0, 1'b0, 32'd0, 32'd0, "post_rst_small");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
